// File: rtl/change_evt_pkg.sv
// Shared widths and the event record layout for the value-change monitor.
// Records carry the new value and the cycle stamp of the detection edge.
package change_evt_pkg;
  localparam int DW_DEF    = 8;
  localparam int TSW_DEF   = 16;
  localparam int DEPTH_DEF = 4;
  localparam int CNTW_DEF  = 8;

  typedef struct packed {
    logic [DW_DEF-1:0]  value;
    logic [TSW_DEF-1:0] ts;
  } evt_entry_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO; rdata shows the head one cycle after push.
// Push on full is taken only alongside a pop; pop on empty is ignored.
module sync_fifo_fwft #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = level_q;
  // Head is forced to zero when empty so stale entries never leak out.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/change_event_fifo.sv
// Value-change monitor: timestamps each enabled change of din and queues it in a FWFT FIFO.
// One cycle from detect edge to evt_valid; changes arriving on a full FIFO with no pop are dropped and counted.
module change_event_fifo
  import change_evt_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int TSW   = TSW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DW-1:0]              din,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [DW-1:0]              evt_value,
  output logic [TSW-1:0]             evt_time,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNTW-1:0]            drop_cnt,
  input  logic                       drop_clr
);
  logic [TSW-1:0]    ts_q, ts_d;
  logic [DW-1:0]     prev_q, prev_d;
  logic [CNTW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [DW+TSW-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              det, pop, push, drop;

  assign det  = en && (din != prev_q);
  assign pop  = evt_valid && evt_ready;
  assign push = det && (!fifo_full || pop);
  assign drop = det && fifo_full && !pop;

  always_comb begin
    ts_d       = ts_q + TSW'(1);
    prev_d     = det ? din : prev_q;
    drop_cnt_d = drop_cnt_q;
    // Clear wins, but a drop in the same cycle still counts once.
    if (drop_clr)                             drop_cnt_d = drop ? CNTW'(1) : '0;
    else if (drop && drop_cnt_q != '1)        drop_cnt_d = drop_cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q       <= '0;
      prev_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DW + TSW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({din, ts_q}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign evt_valid              = !fifo_empty;
  assign {evt_value, evt_time}  = fifo_rdata;
  assign drop_cnt               = drop_cnt_q;
endmodule

// File: tb/tb_change_event_fifo.sv
// Directed bench for change_event_fifo: change sequence, qualifier, overflow, saturation, async reset.
module tb_change_event_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  din;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  evt_value;
  logic [15:0] evt_time;
  logic [2:0]  level;
  logic [1:0]  drop_cnt;
  logic        drop_clr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [23:0] got_q[$];

  change_event_fifo #(.DW(8), .TSW(16), .DEPTH(4), .CNTW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_value (evt_value),
    .evt_time  (evt_time),
    .level     (level),
    .drop_cnt  (drop_cnt),
    .drop_clr  (drop_clr)
  );

  always #5 clk = ~clk;

  // Record every accepted handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) got_q.push_back({evt_value, evt_time});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; cyc is the timestamp the next edge will see.
  task automatic tick();
    @(posedge clk);
    cyc = cyc + 1;
    #2;
  endtask

  task automatic chk_events(input string tag, input int n, input int vals[], input int times[]);
    logic [23:0] e;
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      e = (i < got_q.size()) ? got_q[i] : 24'hffffff;
      chk($sformatf("%s_val%0d", tag, i), e[23:16], vals[i]);
      chk($sformatf("%s_time%0d", tag, i), e[15:0], times[i]);
    end
  endtask

  initial begin
    int t[8];
    int vals[];
    int times[];

    rst = 1'b0; en = 1'b0; din = '0; evt_ready = 1'b0; drop_clr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", evt_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_value", evt_value, 0);

    // Release; the next edge carries timestamp 0.
    rst = 1'b1; en = 1'b1; evt_ready = 1'b1; cyc = 0;
    for (int c = 0; c < 30; c++) begin
      case (c)
        2:  din = 8'd102;
        12: din = 8'd110;
        17: din = 8'd110;
        18: din = 8'd120;
        24: din = 8'd130;
        default: ;
      endcase
      tick();
    end
    vals = '{102, 110, 120, 130};
    times = '{2, 12, 18, 24};
    chk_events("seq", 4, vals, times);

    // Qualifier: changes while disabled are ignored until en returns.
    got_q.delete();
    en = 1'b0; din = 8'd5;
    repeat (3) tick();
    din = 8'd9;
    repeat (3) tick();
    chk("qual_none", got_q.size(), 0);
    en = 1'b1; t[0] = cyc;
    repeat (4) tick();
    vals = '{9};
    times = '{t[0]};
    chk_events("qual", 1, vals, times);

    // Overflow: six changes into a 4-deep FIFO with no consumer.
    got_q.delete();
    evt_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      t[i-1] = cyc; din = 8'(i);
      tick();
    end
    chk("ovf_level", level, 4);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_head_val", evt_value, 1);
    chk("ovf_head_time", evt_time, t[0]);

    // Full with simultaneous push and pop keeps the new event.
    t[6] = cyc; din = 8'd7; evt_ready = 1'b1;
    tick();
    chk("pp_level", level, 4);
    chk("pp_drop", drop_cnt, 2);
    chk("pp_head_val", evt_value, 2);
    repeat (6) tick();
    vals = '{1, 2, 3, 4, 7};
    times = '{t[0], t[1], t[2], t[3], t[6]};
    chk_events("drain", 5, vals, times);
    chk("drain_valid", evt_valid, 0);

    // Saturation of the 2-bit drop counter.
    evt_ready = 1'b0; drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("clr_drop", drop_cnt, 0);
    for (int i = 0; i < 9; i++) begin
      din = 8'(10 + i);
      tick();
    end
    chk("sat_drop", drop_cnt, 3);
    chk("sat_level", level, 4);
    drop_clr = 1'b1; din = 8'd30;
    tick();
    drop_clr = 1'b0;
    chk("clr_and_drop", drop_cnt, 1);
    tick();
    chk("clr_hold", drop_cnt, 1);

    // Async reset mid-stream with three entries held.
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("pre_rst_level", level, 3);
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", evt_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_drop", drop_cnt, 0);
    chk("arst_time", evt_time, 0);
    @(posedge clk);
    #2;
    rst = 1'b1; cyc = 0; din = 8'd0; en = 1'b1; evt_ready = 1'b1;
    got_q.delete();
    repeat (3) tick();
    chk("post_rst_zero", got_q.size(), 0);
    t[0] = cyc; din = 8'd7;
    repeat (3) tick();
    vals = '{7};
    times = '{t[0]};
    chk_events("post_rst", 1, vals, times);
    chk("post_rst_t3", t[0], 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/change_event_fifo.md
Name: change_event_fifo

Overview:
Synthesizable value-change monitor that feeds the event-display stage downstream. It samples a data bus every clock and detects any change in value, with detection gated by an enable qualifier. Each change is queued as a timestamped event record in a small first-word-fall-through FIFO. The consumer pulls records through a valid/ready handshake. Events that arrive while the FIFO is full are dropped and counted.

Parameters:
DW, 8, monitored data width
TSW, 16, timestamp counter width
DEPTH, 4, FIFO entries; power of 2, minimum 2
CNTW, 8, drop counter width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low
en  in  1  detection qualifier; a change is recognised only while en=1
din  in  DW  monitored value
evt_valid  out  1  head record available
evt_ready  in  1  consumer accepts head record
evt_value  out  DW  value after the change
evt_time  out  TSW  timestamp of the detection cycle
level  out  $clog2(DEPTH+1)  FIFO occupancy
drop_cnt  out  CNTW  dropped-event count, saturating
drop_clr  in  1  synchronous clear of drop_cnt

Behaviour:
- Reset (rst=0) is asynchronous and takes effect immediately, including mid-operation:
  - all outputs go to 0: evt_valid=0, evt_value=0, evt_time=0, level=0, drop_cnt=0.
  - prev=0, timestamp counter=0, FIFO emptied; entries held before reset are lost.
- Timestamp counter: increments every clk while out of reset. Wraps from 2^TSW-1 to 0 with no flag.
- Change detect, evaluated each rising edge:
  - det = en && (din != prev).
  - When det=1: prev<=din, and an event {din, ts} is produced, where ts is the counter value before its increment in that cycle.
  - When en=0: prev holds. If din differs from prev when en returns to 1, that first enabled edge produces an event.
  - Rewriting the same value produces no event.
- Baseline after reset is prev=0, so the first enabled non-zero din produces an event.
- Push and pop rules:
  - Push when det=1 and (not full or pop this cycle).
  - Pop when evt_valid && evt_ready.
  - Simultaneous push and pop when full is legal: level stays DEPTH and the event is kept.
  - Pop on empty is ignored.
- Drop: det=1, full, and no pop:
  - the event is discarded;
  - prev still updates;
  - drop_cnt increments, saturating at 2^CNTW-1.
- drop_clr: sets drop_cnt to 0. If drop_clr and a drop occur in the same cycle, drop_cnt=1.
- Output side (first-word fall-through):
  - evt_value and evt_time reflect the head entry whenever evt_valid=1; they hold stable while evt_valid && !evt_ready.
  - Latency: a change sampled at edge N with the FIFO empty gives evt_valid=1 after edge N, i.e. one cycle.
  - evt_valid = (level != 0).
- Pointers are $clog2(DEPTH) bits, wrap modulo DEPTH, plus level tracking. Full = (level==DEPTH).

Decomposition:
- Package change_evt_pkg:
  - typedef evt_entry_t, a packed struct {value[DW], ts[TSW]} using the default widths;
  - localparams for default DW, TSW, DEPTH, CNTW.
- One sub-module, sync_fifo_fwft, a generic FWFT FIFO with parameters WIDTH and DEPTH and ports push, pop, wdata, rdata, full, empty, level.
- The top level holds the timestamp counter, the prev register, detect logic and the drop counter.

Test Plan:
- Value sequence with en=1, evt_ready=1:
  - din=102 at cycle 2, 110 at cycle 12, 110 at cycle 17, 120 at cycle 18, 130 at cycle 24.
  - Required: exactly 4 events, values 102/110/120/130 with evt_time 2/12/18/24, and no event at cycle 17.
- Qualifier:
  - en=0 while din goes 5 then 9: no events.
  - en=1 with din=9 still held: one event, value 9, timestamp of the enable cycle.
- Overflow with evt_ready=0, DEPTH=4:
  - 6 distinct changes give level=4, drop_cnt=2, and the head is the first value.
  - Then evt_ready=1 drains events 1-4 in order and nothing else.
- Full with simultaneous push and pop: with level=4, a change plus a pop in the same cycle gives level=4, drop_cnt unchanged, and the new value appears as the 4th entry.
- Drop counter:
  - CNTW=2 with 5 forced drops gives drop_cnt=3 (saturated).
  - drop_clr in the same cycle as a drop gives drop_cnt=1.
- Async reset mid-stream with level=3:
  - asserting rst between edges immediately gives evt_valid=0, level=0, drop_cnt=0.
  - After release, din=0 produces no event; din=7 produces an event whose evt_time counts from 0 after reset.
